// File: rtl/s_term_frame_loader_if.sv
// Bitstream word channel into the S_term frame loader: 32-bit words with valid/ready handshake.
interface s_term_frame_loader_if #(
  parameter int FRAME_BITS = 32
);
  logic [FRAME_BITS-1:0] in_data;
  logic                  in_valid;
  logic                  in_ready;

  modport master (output in_data, output in_valid, input in_ready);
  modport slave  (input in_data, input in_valid, output in_ready);
endinterface

// File: rtl/s_term_frame_loader.sv
// Configuration frame loader for S_term_single-terminated column strips: sync hunt, WRITE/DESYNC
// decode, FrameData plus one-hot FrameStrobe. Optional checksum: define FRAME_LOADER_CHECKSUM_EN.
module s_term_frame_loader #(
  parameter int                    FRAME_BITS  = 32,
  parameter int                    NUM_COLUMNS = 4,
  parameter int                    MAX_FRAMES  = 20,
  parameter logic [FRAME_BITS-1:0] SYNC_WORD   = FRAME_BITS'(32'hFAB0FAB1)
) (
  input  logic                              CLK,
  input  logic                              reset,
  s_term_frame_loader_if.slave              word_bus,
  output logic [FRAME_BITS-1:0]             FrameData_o,
  output logic [NUM_COLUMNS*MAX_FRAMES-1:0] FrameStrobe_o,
  output logic                              busy_o,
  output logic                              done_o,
  output logic                              err_o,
  output logic [15:0]                       frame_cnt_o
);

  localparam int STROBE_W = NUM_COLUMNS * MAX_FRAMES;
  localparam int IDX_W    = $clog2(STROBE_W);

`ifdef FRAME_LOADER_CHECKSUM_EN
  typedef enum logic [2:0] {HUNT, CMD, DATA, STROBE, CHECK, CHECK_WAIT} state_t;
`else
  typedef enum logic [2:0] {HUNT, CMD, DATA, STROBE, CHECK_WAIT} state_t;
`endif

  state_t state_q, state_d;

  logic             ready;
  logic             fire;
  logic             load_cmd;
  logic             load_data;
  logic             sync_hit;
  logic             set_err;
  logic [7:0]       col_q;
  logic [4:0]       frame_q;
  logic             in_range;
  logic [IDX_W-1:0] strobe_idx;
  logic [STROBE_W-1:0] strobe_vec;
  logic [3:0]       op;

`ifdef FRAME_LOADER_CHECKSUM_EN
  logic [FRAME_BITS-1:0] csum_q;
`endif

  assign op         = word_bus.in_data[31:28];
  assign in_range   = (32'(col_q) < NUM_COLUMNS) && (32'(frame_q) < MAX_FRAMES);
  assign strobe_idx = IDX_W'(32'(col_q) * 32'(MAX_FRAMES) + 32'(frame_q));
  assign strobe_vec = STROBE_W'(1) << strobe_idx;
  assign word_bus.in_ready = ready;

  always_ff @(posedge CLK) begin
    if (reset) state_q <= HUNT;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    ready     = 1'b1;
    busy_o    = (state_q != HUNT);
    done_o    = 1'b0;
    load_cmd  = 1'b0;
    load_data = 1'b0;
    sync_hit  = 1'b0;
    set_err   = 1'b0;
    if (state_q == STROBE || state_q == CHECK_WAIT) ready = 1'b0;
    fire = word_bus.in_valid & ready;
    case (state_q)
      HUNT: begin
        if (fire && word_bus.in_data == SYNC_WORD) begin
          sync_hit = 1'b1;
          state_d  = CMD;
        end
      end
      CMD: begin
        if (fire) begin
          if (op == 4'h1) begin
            load_cmd = 1'b1;
            state_d  = DATA;
          end else if (op == 4'hF) begin
`ifdef FRAME_LOADER_CHECKSUM_EN
            state_d = CHECK;
`else
            state_d = CHECK_WAIT;
`endif
          end else begin
            set_err = 1'b1;
          end
        end
      end
      DATA: begin
        if (fire) begin
          load_data = 1'b1;
          state_d   = STROBE;
        end
      end
      STROBE: state_d = CMD;
`ifdef FRAME_LOADER_CHECKSUM_EN
      CHECK: begin
        if (fire) begin
          if (word_bus.in_data == csum_q) begin
            state_d = CHECK_WAIT;
          end else begin
            set_err = 1'b1;
            state_d = HUNT;
          end
        end
      end
`endif
      CHECK_WAIT: begin
        done_o  = 1'b1;
        state_d = HUNT;
      end
      default: state_d = HUNT;
    endcase
  end

  // Strobe, error and count are registered on the data-accept edge so they line up with the
  // STROBE state; a reset on that same edge therefore drops the pending strobe.
  always_ff @(posedge CLK) begin
    if (reset) begin
      FrameData_o   <= '0;
      FrameStrobe_o <= '0;
      err_o         <= 1'b0;
      frame_cnt_o   <= '0;
      col_q         <= '0;
      frame_q       <= '0;
`ifdef FRAME_LOADER_CHECKSUM_EN
      csum_q        <= '0;
`endif
    end else begin
      FrameStrobe_o <= '0;
      if (sync_hit) begin
        err_o       <= 1'b0;
        frame_cnt_o <= '0;
`ifdef FRAME_LOADER_CHECKSUM_EN
        csum_q      <= '0;
`endif
      end
      if (set_err) err_o <= 1'b1;
      if (load_cmd) begin
        col_q   <= word_bus.in_data[23:16];
        frame_q <= word_bus.in_data[4:0];
      end
      if (load_data) begin
        FrameData_o <= word_bus.in_data;
`ifdef FRAME_LOADER_CHECKSUM_EN
        csum_q      <= csum_q ^ word_bus.in_data;
`endif
        if (in_range) begin
          FrameStrobe_o <= strobe_vec;
          if (frame_cnt_o != '1) frame_cnt_o <= frame_cnt_o + 16'd1;
        end else begin
          err_o <= 1'b1;
        end
      end
    end
  end

endmodule
